write_result_seq: RTL and testbench

WRITE_RESULT_SEQ -- requirements
Module: write_result_seq

---
 rtl/write_result_seq_pkg.sv | 17 +
 rtl/write_result_seq.sv | 108 ++++++++++
 tb/tb_write_result_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/write_result_seq_pkg.sv
// Shared convolution package: write-out FSM encodings, trigger default and width helper.
package write_result_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  localparam logic [3:0] TRIG_STATE_DEF = 4'd5;

  // $clog2 floored at one bit so single-word/single-channel configs keep a real port
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/write_result_seq.sv
// Sequences the write-out of one result (OUTPUT_SIZE words x NUM_CH channels)
// with ready/valid handshake, launched by the rising edge of the trigger condition.
module write_result_seq
  import write_result_seq_pkg::*;
#(
  parameter int         OUTPUT_SIZE = 10,
  parameter int         NUM_CH      = 1,
  parameter logic [3:0] TRIG_STATE  = TRIG_STATE_DEF,
  localparam int        SEL_W       = clog2_min1(OUTPUT_SIZE),
  localparam int        CH_W        = clog2_min1(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       state,
  input  logic [15:0]      counter_ifm,
  input  logic [3:0]       counter_compute,
  input  logic             ready,
  input  logic             overrun_clr,
  output logic             valid_data,
  output logic [SEL_W-1:0] sel_data,
  output logic [CH_W-1:0]  ch_sel,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(OUTPUT_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  wr_state_t        st_q, st_d;
  logic             trig, trig_q, armed_q, trig_rise, xfer;
  logic             valid_d, last_d, done_d;
  logic [SEL_W-1:0] sel_d;
  logic [CH_W-1:0]  ch_d;

  assign trig = (state == TRIG_STATE) && (counter_ifm == 16'd0) && (counter_compute != 4'd0);
  // armed_q blocks a trigger that was already high when reset released
  assign trig_rise = trig && !trig_q && armed_q;
  assign xfer      = valid_data && ready;

  always_comb begin
    st_d    = st_q;
    valid_d = 1'b0;
    sel_d   = '0;
    ch_d    = '0;
    done_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (trig_rise) begin
          st_d    = ST_WRITE;
          valid_d = 1'b1;
        end
      end
      ST_WRITE: begin
        valid_d = 1'b1;
        sel_d   = sel_data;
        ch_d    = ch_sel;
        if (xfer) begin
          if (last) begin
            st_d    = ST_DONE;
            valid_d = 1'b0;
            sel_d   = '0;
            ch_d    = '0;
            done_d  = 1'b1;
          end else if (sel_data == SEL_LAST) begin
            sel_d = '0;
            ch_d  = ch_sel + CH_W'(1);
          end else begin
            sel_d = sel_data + SEL_W'(1);
          end
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    last_d = valid_d && (sel_d == SEL_LAST) && (ch_d == CH_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      trig_q     <= 1'b0;
      armed_q    <= 1'b0;
      valid_data <= 1'b0;
      sel_data   <= '0;
      ch_sel     <= '0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      st_q       <= st_d;
      trig_q     <= trig;
      if (!trig) armed_q <= 1'b1;
      valid_data <= valid_d;
      sel_data   <= sel_d;
      ch_sel     <= ch_d;
      last       <= last_d;
      busy       <= (st_d != ST_IDLE);
      done       <= done_d;
      // a new trigger while busy wins over a same-cycle clear
      if (trig_rise && (st_q != ST_IDLE)) overrun <= 1'b1;
      else if (overrun_clr)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_result_seq.sv
// Directed bench for write_result_seq: 4x2 stream scenarios plus a 1x1 instance.
module tb_write_result_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] st_a, st_b;
  logic [15:0] counter_ifm;
  logic [3:0] counter_compute;
  logic       ready, overrun_clr;

  logic       valid_a, last_a, busy_a, done_a, ovr_a;
  logic [1:0] sel_a;
  logic [0:0] ch_a;
  logic       valid_b, last_b, busy_b, done_b, ovr_b;
  logic [0:0] sel_b;
  logic [0:0] ch_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  write_result_seq #(.OUTPUT_SIZE(4), .NUM_CH(2)) u_dut (
    .clk(clk), .rst(rst), .state(st_a), .counter_ifm(counter_ifm),
    .counter_compute(counter_compute), .ready(ready), .overrun_clr(overrun_clr),
    .valid_data(valid_a), .sel_data(sel_a), .ch_sel(ch_a), .last(last_a),
    .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  write_result_seq #(.OUTPUT_SIZE(1), .NUM_CH(1)) u_dut1 (
    .clk(clk), .rst(rst), .state(st_b), .counter_ifm(counter_ifm),
    .counter_compute(counter_compute), .ready(ready), .overrun_clr(overrun_clr),
    .valid_data(valid_b), .sel_data(sel_b), .ch_sel(ch_b), .last(last_b),
    .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input int cyc, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // hand-derived word index per cycle (-1 = no valid word)
  function automatic int exp_word(input int id, input int c);
    if ((id == 1 || id == 4) && c >= 11 && c <= 18) return c - 11;
    if (id == 2) begin
      if (c >= 11 && c <= 13) return c - 11;
      if (c >= 14 && c <= 16) return 2;
      if (c >= 17 && c <= 21) return c - 14;
    end
    if (id == 3) begin
      if (c >= 11 && c <= 18) return c - 11;
      if (c >= 41 && c <= 48) return c - 41;
    end
    if (id == 5) begin
      if (c >= 11 && c <= 14) return c - 11;
      if (c == 34) return 0;
    end
    return -1;
  endfunction

  function automatic bit exp_done(input int id, input int c);
    if ((id == 1 || id == 4) && c == 19) return 1'b1;
    if (id == 2 && c == 22) return 1'b1;
    if (id == 3 && (c == 19 || c == 49)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_ovr(input int id, input int c);
    return (id == 3) && ((c >= 15 && c <= 30) || c >= 45);
  endfunction

  function automatic bit trig_on(input int id, input int c);
    if (id == 1 || id == 2) return (c == 10);
    if (id == 3) return (c == 10 || c == 14 || c == 40 || c == 44);
    if (id == 4) return (c >= 10 && c <= 29);
    if (id == 5) return (c >= 10 && c <= 30) || (c >= 33);
    return 1'b0;
  endfunction

  task automatic run_scn(input int id, input int ncyc);
    int w;
    bit d;
    for (int c = 0; c <= ncyc; c++) begin
      if (c >= 1) begin
        w = exp_word(id, c);
        d = exp_done(id, c);
        check("valid",   c, int'(valid_a), int'(w >= 0));
        check("sel",     c, int'(sel_a),   (w >= 0) ? w % 4 : 0);
        check("ch",      c, int'(ch_a),    (w >= 0) ? w / 4 : 0);
        check("last",    c, int'(last_a),  int'(w == 7));
        check("done",    c, int'(done_a),  int'(d));
        check("busy",    c, int'(busy_a),  int'((w >= 0) || d));
        check("overrun", c, int'(ovr_a),   int'(exp_ovr(id, c)));
      end
      rst             = (c <= 1) || (id == 5 && c == 14);
      ready           = !(id == 2 && c >= 13 && c <= 15);
      overrun_clr     = (id == 3) && (c == 30 || c == 44);
      counter_compute = (id == 1 && c >= 3 && c <= 5) ? 4'd0 : 4'd3;
      counter_ifm     = (id == 1 && c >= 6 && c <= 7) ? 16'd1 : 16'd0;
      // cycles 3..7 of scenario 1 present state 5 with a gating counter wrong
      st_a = (trig_on(id, c) || (id == 1 && c >= 3 && c <= 7)) ? 4'd5 : 4'd0;
      st_b = 4'd0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_single();
    for (int c = 0; c <= 9; c++) begin
      if (c >= 1) begin
        check("s_valid", c, int'(valid_b), int'(c == 6));
        check("s_last",  c, int'(last_b),  int'(c == 6));
        check("s_sel",   c, int'(sel_b),   0);
        check("s_ch",    c, int'(ch_b),    0);
        check("s_done",  c, int'(done_b),  int'(c == 7));
        check("s_busy",  c, int'(busy_b),  int'(c == 6 || c == 7));
        check("s_ovr",   c, int'(ovr_b),   0);
      end
      rst             = (c <= 1);
      ready           = 1'b1;
      overrun_clr     = 1'b0;
      counter_compute = 4'd3;
      counter_ifm     = 16'd0;
      st_a            = 4'd0;
      st_b            = (c == 5) ? 4'd5 : 4'd0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; st_a = 4'd0; st_b = 4'd0; counter_ifm = 16'd0;
    counter_compute = 4'd0; ready = 1'b1; overrun_clr = 1'b0;
    @(posedge clk); #1;
    run_scn(1, 24);
    run_scn(2, 26);
    run_scn(3, 52);
    run_scn(4, 34);
    run_scn(5, 34);
    run_single();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
